// File: rtl/hps_spi_pkg.sv
// Shared types and constants for the HPS-side SPI command channel master.
package hps_spi_pkg;

  localparam int WORD_W = 16;
  localparam int BIT_W  = $clog2(WORD_W);

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    SHIFT,
    HOLD,
    IDLE_GAP
  } state_e;

endpackage

// File: rtl/hps_spi_master_if.sv
// Word-stream handshake between the command-channel user and the SPI master.
interface hps_spi_master_if;
  import hps_spi_pkg::*;

  logic [WORD_W-1:0] tx_data;
  logic              tx_last;
  logic              tx_valid;
  logic              tx_ready;
  logic [WORD_W-1:0] rx_data;
  logic              rx_valid;

  modport master (
    output tx_data, tx_last, tx_valid,
    input  tx_ready, rx_data, rx_valid
  );

  modport slave (
    input  tx_data, tx_last, tx_valid,
    output tx_ready, rx_data, rx_valid
  );

endinterface

// File: rtl/spi_clk_gen.sv
// Half-period tick generator: one-cycle pulse every CLK_DIV cycles, restartable so
// every state begins on an exact phase boundary.
module spi_clk_gen #(
  parameter int CLK_DIV = 4
) (
  input  logic sys_clk,
  input  logic reset,
  input  logic clear_i,
  output logic tick_o
);

  localparam int CNT_W = $clog2(CLK_DIV);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLK_DIV - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (clear_i || (cnt_q == CNT_MAX)) cnt_d = '0;
  end

  // NOTE: sequential state is updated with non-blocking assignments only, so every
  // register samples the pre-edge value of every other register.
  always_ff @(posedge sys_clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign tick_o = (cnt_q == CNT_MAX);

endmodule

// File: rtl/hps_spi_master.sv
// HPS-side SPI master (CPOL=0, CPHA=0): full-duplex 16-bit words with CS held across
// words until tx_last, plus registered copies of the io/osd/fpga enable requests.
module hps_spi_master
  import hps_spi_pkg::*;
#(
  parameter int CLK_DIV  = 4,
  parameter int CS_SETUP = 1,
  parameter int CS_IDLE  = 2
) (
  input  logic            sys_clk,
  input  logic            reset,
  hps_spi_master_if.slave bus,
  output logic            busy,
  input  logic            en_io,
  input  logic            en_osd,
  input  logic            en_fpga,
  output logic            io_enable,
  output logic            osd_enable,
  output logic            fpga_enable,
  output logic            spi_clk,
  output logic            spi_mosi,
  output logic            spi_cs,
  input  logic            spi_miso
);

  localparam int HC_MAX = (CS_SETUP > CS_IDLE) ? CS_SETUP : CS_IDLE;
  localparam int HC_W   = $clog2(HC_MAX + 1);

  state_e            state_q, state_d;
  logic [HC_W-1:0]   hc_q, hc_d;
  logic [BIT_W-1:0]  bit_q, bit_d;
  logic [WORD_W-1:0] tx_sh_q, tx_sh_d;
  logic [WORD_W-1:0] rx_sh_q, rx_sh_d;
  logic [WORD_W-1:0] rx_data_q, rx_data_d;
  logic              last_q, last_d;
  logic              cs_q, cs_d;
  logic              sck_q, sck_d;
  logic              mosi_q, mosi_d;
  logic              rx_valid_q, rx_valid_d;
  logic              ready_q, ready_d;
  logic [2:0]        en_q;
  logic              tick;
  logic              accept;

  spi_clk_gen #(.CLK_DIV(CLK_DIV)) u_clk_gen (
    .sys_clk (sys_clk),
    .reset   (reset),
    .clear_i (state_d != state_q),
    .tick_o  (tick)
  );

  assign accept = bus.tx_valid && ready_q;

  // NOTE: every next-state signal takes its default before the case statement, so no
  // path through the block can leave one unassigned and infer a latch.
  always_comb begin
    state_d    = state_q;
    hc_d       = hc_q;
    bit_d      = bit_q;
    tx_sh_d    = tx_sh_q;
    rx_sh_d    = rx_sh_q;
    rx_data_d  = rx_data_q;
    last_d     = last_q;
    cs_d       = cs_q;
    sck_d      = sck_q;
    mosi_d     = mosi_q;
    rx_valid_d = 1'b0;

    unique case (state_q)
      IDLE, HOLD: begin
        if (accept) begin
          tx_sh_d = bus.tx_data;
          last_d  = bus.tx_last;
          mosi_d  = bus.tx_data[WORD_W-1];
          cs_d    = 1'b1;
          state_d = SETUP;
        end
      end
      SETUP: begin
        if (tick) begin
          if (hc_q == HC_W'(CS_SETUP - 1)) begin
            bit_d   = BIT_W'(WORD_W - 1);
            mosi_d  = tx_sh_q[WORD_W-1];
            state_d = SHIFT;
          end else begin
            hc_d = hc_q + 1'b1;
          end
        end
      end
      SHIFT: begin
        if (tick) begin
          if (!sck_q) begin
            sck_d   = 1'b1;
            rx_sh_d = {rx_sh_q[WORD_W-2:0], spi_miso};
          end else begin
            sck_d = 1'b0;
            if (bit_q != '0) begin
              tx_sh_d = tx_sh_q << 1;
              mosi_d  = tx_sh_q[WORD_W-2];
              bit_d   = bit_q - 1'b1;
            end else begin
              rx_data_d  = rx_sh_q;
              rx_valid_d = 1'b1;
              cs_d       = !last_q;
              state_d    = last_q ? IDLE_GAP : HOLD;
            end
          end
        end
      end
      IDLE_GAP: begin
        if (tick) begin
          if (hc_q == HC_W'(CS_IDLE - 1)) state_d = IDLE;
          else                            hc_d    = hc_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (state_d != state_q) hc_d = '0;

    // Ready is held off during the rx_valid cycle so a strobe and an accept never coincide.
    ready_d = ((state_d == IDLE) || (state_d == HOLD)) && !rx_valid_d;
  end

  always_ff @(posedge sys_clk) begin
    if (reset) begin
      state_q    <= IDLE;
      hc_q       <= '0;
      bit_q      <= '0;
      tx_sh_q    <= '0;
      rx_sh_q    <= '0;
      rx_data_q  <= '0;
      last_q     <= 1'b0;
      cs_q       <= 1'b0;
      sck_q      <= 1'b0;
      mosi_q     <= 1'b0;
      rx_valid_q <= 1'b0;
      ready_q    <= 1'b0;
      en_q       <= '0;
    end else begin
      state_q    <= state_d;
      hc_q       <= hc_d;
      bit_q      <= bit_d;
      tx_sh_q    <= tx_sh_d;
      rx_sh_q    <= rx_sh_d;
      rx_data_q  <= rx_data_d;
      last_q     <= last_d;
      cs_q       <= cs_d;
      sck_q      <= sck_d;
      mosi_q     <= mosi_d;
      rx_valid_q <= rx_valid_d;
      ready_q    <= ready_d;
      en_q       <= {en_io, en_osd, en_fpga};
    end
  end

  assign bus.tx_ready = ready_q;
  assign bus.rx_data  = rx_data_q;
  assign bus.rx_valid = rx_valid_q;
  assign busy         = (state_q != IDLE);
  assign spi_cs       = cs_q;
  assign spi_clk      = sck_q;
  assign spi_mosi     = mosi_q;
  assign io_enable    = en_q[2];
  assign osd_enable   = en_q[1];
  assign fpga_enable  = en_q[0];

endmodule

// File: tb/tb_hps_spi_master.sv
// Bench for hps_spi_master: a frame-timeline model derived from the word timing rules,
// a loopback SPI slave, and a per-cycle compare against both.
module tb_hps_spi_master;
  import hps_spi_pkg::*;

  localparam int D = 4;
  localparam int S = 1;
  localparam int I = 2;
  localparam int W = (S + 32) * D;

  logic sys_clk = 1'b0;
  logic reset   = 1'b1;
  logic en_io = 1'b0, en_osd = 1'b0, en_fpga = 1'b0;
  logic io_enable, osd_enable, fpga_enable;
  logic spi_clk, spi_mosi, spi_cs, busy;
  logic spi_miso = 1'b0;

  hps_spi_master_if bus();

  hps_spi_master #(.CLK_DIV(D), .CS_SETUP(S), .CS_IDLE(I)) dut (
    .sys_clk     (sys_clk),
    .reset       (reset),
    .bus         (bus),
    .busy        (busy),
    .en_io       (en_io),
    .en_osd      (en_osd),
    .en_fpga     (en_fpga),
    .io_enable   (io_enable),
    .osd_enable  (osd_enable),
    .fpga_enable (fpga_enable),
    .spi_clk     (spi_clk),
    .spi_mosi    (spi_mosi),
    .spi_cs      (spi_cs),
    .spi_miso    (spi_miso)
  );

  always #5 sys_clk = ~sys_clk;

  int cyc = 0;
  always @(posedge sys_clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Timeline model state: the most recent accepted word and where it started.
  bit          have = 0;
  int          a = 0;
  logic [15:0] cur_w = '0;
  bit          cur_last = 0;
  int          rst_edge = -1;
  logic [15:0] exp_rx_data = '0;
  logic [2:0]  prev_en = '0;
  logic [15:0] exp_tx_q[$];
  logic [15:0] slave_sent_q[$];
  logic [15:0] miso_q[$];
  int          acc_count = 0, last_acc = 0;
  int          rv_count = 0, last_rv_cyc = 0;

  // Loopback slave state.
  logic [15:0] s_cur = '0, s_rx = '0, last_slave_word = '0;
  int          s_cnt = 0, strobes = 0, rises_frame = 0, last_frame_rises = 0;
  int          hi_run = 0, lo_run = 0;
  logic        prev_cs = 1'b0, prev_sck = 1'b0;
  bit          en_rand = 0;

  task automatic slave_load();
    s_cur    = (miso_q.size() > 0) ? miso_q.pop_front() : 16'h0000;
    spi_miso = s_cur[15];
  endtask

  always @(negedge sys_clk) begin
    int k, m;
    logic e_cs, e_sck, e_rv, e_rdy, e_busy, e_mosi;
    bit chk_mosi;

    if (rst_edge >= 0 && cyc >= rst_edge) begin
      chk_mosi = 0;
      e_mosi   = 1'b0;
      if (have) begin
        k      = cyc - a;
        e_cs   = (k < W) ? 1'b1 : !cur_last;
        e_sck  = (k >= (S + 1) * D) && (k < W) && (((k / D - S - 1) % 2) == 0);
        e_rv   = (k == W);
        e_rdy  = cur_last ? (k >= W + I * D) : (k >= W + 1);
        e_busy = cur_last ? (k < W + I * D) : 1'b1;
        if (k >= S * D && k < W) begin
          m        = (k / D - S) / 2;
          chk_mosi = 1;
          e_mosi   = cur_w[15 - m];
        end
        if (k == W) begin
          if (slave_sent_q.size() == 0) check("rx_word_available", 0, 1);
          else exp_rx_data = slave_sent_q.pop_front();
        end
      end else begin
        e_cs = 1'b0; e_sck = 1'b0; e_rv = 1'b0; e_busy = 1'b0;
        e_rdy    = (cyc > rst_edge);
        chk_mosi = 1;
      end
      check("spi_cs", spi_cs, e_cs);
      check("spi_clk", spi_clk, e_sck);
      check("rx_valid", bus.rx_valid, e_rv);
      check("tx_ready", bus.tx_ready, e_rdy);
      check("busy", busy, e_busy);
      check("rx_data", bus.rx_data, exp_rx_data);
      if (chk_mosi) check("spi_mosi", spi_mosi, e_mosi);
      check("enables", {io_enable, osd_enable, fpga_enable},
            (cyc == rst_edge) ? 3'b000 : prev_en);
    end
    prev_en = {en_io, en_osd, en_fpga};

    if (bus.rx_valid === 1'b1) begin
      rv_count++;
      last_rv_cyc = cyc;
    end

    // SCK run lengths inside a word.
    if (spi_clk !== prev_sck) begin
      if (!spi_clk && cyc != rst_edge) check("sck_high_cycles", hi_run, 4);
      if (spi_clk && spi_cs && s_cnt > 0) check("sck_low_cycles", lo_run, 4);
      hi_run = 0;
      lo_run = 0;
    end
    if (spi_clk) hi_run++;
    else         lo_run++;

    // Loopback slave: MOSI captured at SCK rise, MISO presented MSB first.
    if (spi_cs && !prev_cs) begin
      s_cnt = 0;
      rises_frame = 0;
      slave_load();
    end else if (!spi_cs && prev_cs && cyc != rst_edge) begin
      last_frame_rises = rises_frame;
    end
    if (spi_cs) begin
      if (spi_clk && !prev_sck) begin
        s_rx = {s_rx[14:0], spi_mosi};
        s_cnt++;
        rises_frame++;
        if (s_cnt == 16) begin
          strobes++;
          last_slave_word = s_rx;
          if (exp_tx_q.size() == 0) check("slave_word_expected", 0, 1);
          else check("slave_word", s_rx, exp_tx_q.pop_front());
          slave_sent_q.push_back(s_cur);
          s_cnt = 0;
          slave_load();
        end else begin
          spi_miso = s_cur[15 - s_cnt];
        end
      end
    end else begin
      s_cnt = 0;
    end
    prev_cs  = spi_cs;
    prev_sck = spi_clk;

    if (reset) begin
      rst_edge    = cyc + 1;
      have        = 0;
      exp_rx_data = '0;
      exp_tx_q.delete();
      slave_sent_q.delete();
    end else if (bus.tx_valid && bus.tx_ready) begin
      have     = 1;
      a        = cyc + 1;
      cur_w    = bus.tx_data;
      cur_last = bus.tx_last;
      exp_tx_q.push_back(bus.tx_data);
      acc_count++;
      last_acc = a;
    end
  end

  always @(posedge sys_clk) begin
    if (en_rand) begin
      #1;
      {en_io, en_osd, en_fpga} = 3'($urandom);
    end
  end

  task automatic step();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic send(input logic [15:0] w, input logic last);
    int t = 0;
    bit done = 0;
    bus.tx_valid = 1'b1;
    bus.tx_data  = w;
    bus.tx_last  = last;
    while (!done) begin
      @(negedge sys_clk);
      if (bus.tx_ready === 1'b1) done = 1;
      else if (++t > 2000) begin
        check("accept_timeout", 0, 1);
        done = 1;
      end
    end
    step();
    bus.tx_valid = 1'b0;
    bus.tx_data  = 16'($urandom);
    bus.tx_last  = 1'($urandom);
  endtask

  task automatic wait_idle();
    int t = 0;
    bit done = 0;
    while (!done) begin
      @(negedge sys_clk);
      if (busy === 1'b0 && bus.tx_ready === 1'b1) done = 1;
      else if (++t > 2000) begin
        check("idle_timeout", 0, 1);
        done = 1;
      end
    end
    step();
  endtask

  task automatic wait_bits(input int n);
    int t = 0;
    bit done = 0;
    while (!done) begin
      @(negedge sys_clk);
      if (s_cnt == n) done = 1;
      else if (++t > 2000) begin
        check("bit_wait_timeout", 0, 1);
        done = 1;
      end
    end
  endtask

  initial begin
    int rv0, st0, acc0, first_acc;
    bus.tx_valid = 1'b0;
    bus.tx_data  = '0;
    bus.tx_last  = 1'b0;
    repeat (3) step();
    reset = 1'b0;

    @(negedge sys_clk);
    check("rst_cs", spi_cs, 0);
    check("rst_sck", spi_clk, 0);
    check("rst_mosi", spi_mosi, 0);
    check("rst_ready", bus.tx_ready, 0);
    check("rst_rx_data", bus.rx_data, 0);
    check("rst_busy", busy, 0);
    step();

    // Single word with last.
    miso_q.delete();
    miso_q.push_back(16'h3C0F);
    rv0 = rv_count;
    send(16'hA55A, 1'b1);
    wait_idle();
    check("t1_slave_word", last_slave_word, 16'hA55A);
    check("t1_rx_data", bus.rx_data, 16'h3C0F);
    check("t1_cs_low", spi_cs, 0);
    check("t1_rx_strobes", rv_count - rv0, 1);
    check("t1_accept_to_rx_valid", last_rv_cyc - (last_acc - 1), 133);

    // Two words in one CS frame.
    miso_q.push_back(16'($urandom));
    miso_q.push_back(16'($urandom));
    rv0 = rv_count;
    st0 = strobes;
    send(16'h0001, 1'b0);
    send(16'h8000, 1'b1);
    wait_idle();
    check("t2_sck_rises", last_frame_rises, 32);
    check("t2_slave_strobes", strobes - st0, 2);
    check("t2_rx_strobes", rv_count - rv0, 2);
    check("t2_last_word", last_slave_word, 16'h8000);
    miso_q.delete();

    // tx_valid held while busy: second accept only once back in IDLE.
    acc0 = acc_count;
    send(16'h1111, 1'b1);
    first_acc = last_acc;
    send(16'h2222, 1'b1);
    check("t5_accept_spacing", last_acc - first_acc, 141);
    check("t5_accepts", acc_count - acc0, 2);
    wait_idle();

    // Reset while bit 7 is on the wire.
    rv0 = rv_count;
    bus.tx_valid = 1'b1;
    bus.tx_data  = 16'hBEEF;
    bus.tx_last  = 1'b1;
    @(negedge sys_clk);
    step();
    bus.tx_valid = 1'b0;
    wait_bits(9);
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    @(negedge sys_clk);
    check("t4_cs_after_reset", spi_cs, 0);
    check("t4_sck_after_reset", spi_clk, 0);
    repeat (5) step();
    check("t4_no_rx_valid", rv_count - rv0, 0);
    miso_q.push_back(16'h5AA5);
    send(16'h1234, 1'b1);
    wait_idle();
    check("t4_slave_word", last_slave_word, 16'h1234);
    check("t4_rx_data", bus.rx_data, 16'h5AA5);

    // Enables follow one cycle later, mid-frame.
    send(16'hC3C3, 1'b1);
    repeat (20) step();
    {en_io, en_osd, en_fpga} = 3'b101;
    @(negedge sys_clk);
    check("t6_enables_before", {io_enable, osd_enable, fpga_enable}, 3'b000);
    @(negedge sys_clk);
    check("t6_enables_after", {io_enable, osd_enable, fpga_enable}, 3'b101);
    step();
    wait_idle();
    check("t6_slave_word", last_slave_word, 16'hC3C3);

    // Randomized traffic with random enables and random frame lengths.
    en_rand = 1;
    for (int n = 0; n < 25; n++) begin
      repeat ($urandom_range(0, 12)) step();
      miso_q.push_back(16'($urandom));
      send(16'($urandom), (n == 24) ? 1'b1 : 1'($urandom));
    end
    wait_idle();
    en_rand = 0;
    repeat (4) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
    $fatal(1);
  end

endmodule
